pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter PERF_W, default 32: width of each performance counter.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 imem_stall  in  1  instruction fetch outstanding; IF/ID input invalid this cycle.
REQ-005 dmem_stall  in  1  data access in MEM outstanding.
REQ-006 id_rs1_idx, id_rs2_idx  in  5 each  source register indices of the instruction in ID.
REQ-007 id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1 / rs2.
REQ-008 ex_rd  in  5  destination index held in ID/EX.
REQ-009 ex_is_load  in  1  ID/EX holds a load.
REQ-010 ex_mispredict  in  1  branch/jump resolved in EX disagrees with prediction.
REQ-011 load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  load enables to the PC and the four pipeline registers.
REQ-012 flush_if_id, flush_id_ex  out  1 each  when loaded, register captures all-zero (bubble) contents.
REQ-013 ctrl_state  out  1  current FSM state (0 RUN, 1 DRAIN).
REQ-014 stall_cycles, flush_count  out  PERF_W each  present only with PIPE_CTRL_PERF_EN.

Function
REQ-015 Outputs SHALL be combinational from state and inputs; the only state is the FSM plus optional counters.
REQ-016 Priority SHALL be: dmem_stall > ex_mispredict > imem_stall > load-use hazard > normal advance.
REQ-017 Normal advance (RUN, no condition): all load_* = 1, all flush_* = 0.
REQ-018 dmem_stall = 1: all load_* = 0, flushes 0, state held; mispredict acted on only after dmem_stall falls (EX frozen, so ex_mispredict persists).
REQ-019 Mispredict in RUN: load_pc = 1, all loads 1, flush_if_id = flush_id_ex = 1; if imem_stall = 1 same cycle, next state DRAIN, else stay RUN.
REQ-020 imem_stall in RUN (no mispredict): load_pc = load_if_id = 0; load_id_ex = 1 with flush_id_ex = 1; EX/MEM, MEM/WB load 1.
REQ-021 Load-use hazard = ex_is_load AND ex_rd != 0 AND ((id_uses_rs1 AND id_rs1_idx == ex_rd) OR (id_uses_rs2 AND id_rs2_idx == ex_rd)); response identical to REQ-020; lasts exactly one cycle since the inserted bubble clears ex_is_load.
REQ-022 DRAIN with imem_stall = 1: identical to REQ-020.
REQ-023 DRAIN with imem_stall = 0: wrong-path instruction discarded: load_pc = 0, load_if_id = 1 with flush_if_id = 1, load_id_ex = 1 with flush_id_ex = 1; next state RUN.
REQ-024 Mispredict seen in DRAIN SHALL be handled per REQ-019 (re-redirect), remaining in DRAIN if imem_stall = 1.
REQ-025 ex_rd = 0 SHALL never create a hazard.

Reset
REQ-026 While rst = 1: all load_* = 0, all flush_* = 0; next state RUN; counters cleared to 0.
REQ-027 rst mid-DRAIN SHALL abandon the pending discard; first post-reset cycle is RUN.

Configuration
REQ-028 Macro PIPE_CTRL_PERF_EN defined: stall_cycles increments (wrapping) each non-reset cycle with load_pc = 0; flush_count increments each cycle flush_if_id = 1.
REQ-029 Macro undefined: counter ports and logic absent; all other behaviour identical.

Structure
REQ-030 ctrl state enum (RUN, DRAIN) SHALL live in rv32i_types; hazard compare SHALL be sub-module hazard_detect (combinational, REQ-021).

Verification
REQ-031 Load x5, then add using x5 as rs2 -> one cycle load_pc = load_if_id = 0, flush_id_ex = 1; next cycle all loads 1.
REQ-032 Load x0, consumer reads x0 -> no stall.
REQ-033 imem_stall 3 cycles, ex_mispredict in cycle 1 -> load_pc = 1 cycle 1, ctrl_state = 1 cycles 2-3, on imem_stall fall flush_if_id = 1, load_pc = 0, then RUN.
REQ-034 dmem_stall 4 cycles with ex_mispredict and hazard asserted -> all loads 0 for 4 cycles, redirect on cycle 5.
REQ-035 rst asserted in DRAIN -> loads 0 during rst, ctrl_state = 0 after; with PIPE_CTRL_PERF_EN counters read 0.
REQ-036 PIPE_CTRL_PERF_EN: 2 load-use stalls + 1 mispredict -> stall_cycles = 2, flush_count = 1.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the pipeline controller: control FSM states and register-index width.
package rv32i_types;

  localparam int unsigned RegIdxW = 5;

  typedef enum logic {
    StRun   = 1'b0,
    StDrain = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Control bus between the datapath (master) and pipeline_ctrl (slave).
// Counter signals exist only when PIPE_CTRL_PERF_EN is defined.
interface pipeline_ctrl_if #(
  parameter int unsigned PERF_W = 32
);
  import rv32i_types::*;

  logic               imem_stall;
  logic               dmem_stall;
  logic [RegIdxW-1:0] id_rs1_idx;
  logic [RegIdxW-1:0] id_rs2_idx;
  logic               id_uses_rs1;
  logic               id_uses_rs2;
  logic [RegIdxW-1:0] ex_rd;
  logic               ex_is_load;
  logic               ex_mispredict;

  logic               load_pc;
  logic               load_if_id;
  logic               load_id_ex;
  logic               load_ex_mem;
  logic               load_mem_wb;
  logic               flush_if_id;
  logic               flush_id_ex;
  logic               ctrl_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0]  stall_cycles;
  logic [PERF_W-1:0]  flush_count;
`endif

  modport master (
    output imem_stall, dmem_stall, id_rs1_idx, id_rs2_idx, id_uses_rs1, id_uses_rs2,
           ex_rd, ex_is_load, ex_mispredict,
    input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, flush_id_ex, ctrl_state
`ifdef PIPE_CTRL_PERF_EN
    , input stall_cycles, flush_count
`endif
  );

  modport slave (
    input  imem_stall, dmem_stall, id_rs1_idx, id_rs2_idx, id_uses_rs1, id_uses_rs2,
           ex_rd, ex_is_load, ex_mispredict,
    output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, flush_id_ex, ctrl_state
`ifdef PIPE_CTRL_PERF_EN
    , output stall_cycles, flush_count
`endif
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register the ID instruction reads.
// x0 is never a real dependency.
module hazard_detect
  import rv32i_types::*;
(
  input  logic               i_ex_is_load,
  input  logic [RegIdxW-1:0] i_ex_rd,
  input  logic [RegIdxW-1:0] i_rs1_idx,
  input  logic [RegIdxW-1:0] i_rs2_idx,
  input  logic               i_uses_rs1,
  input  logic               i_uses_rs2,
  output logic               o_hazard
);

  logic w_rs1_match;
  logic w_rs2_match;

  assign w_rs1_match = i_uses_rs1 && (i_rs1_idx == i_ex_rd);
  assign w_rs2_match = i_uses_rs2 && (i_rs2_idx == i_ex_rd);
  assign o_hazard    = i_ex_is_load && (i_ex_rd != '0) && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline stall/flush controller. Outputs are combinational from the
// RUN/DRAIN FSM and the inputs. Optional performance counters: PIPE_CTRL_PERF_EN.
module pipeline_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned PERF_W = 32
) (
  input logic           clk,
  input logic           rst,
  pipeline_ctrl_if.slave bus
);

  ctrl_state_e r_state;
  ctrl_state_e w_state_d;
  logic        w_hazard;
  logic        w_load_pc, w_load_if_id, w_load_id_ex, w_load_ex_mem, w_load_mem_wb;
  logic        w_flush_if_id, w_flush_id_ex;

  hazard_detect u_hazard_detect (
    .i_ex_is_load (bus.ex_is_load),
    .i_ex_rd      (bus.ex_rd),
    .i_rs1_idx    (bus.id_rs1_idx),
    .i_rs2_idx    (bus.id_rs2_idx),
    .i_uses_rs1   (bus.id_uses_rs1),
    .i_uses_rs2   (bus.id_uses_rs2),
    .o_hazard     (w_hazard)
  );

  // FSM state register; reset abandons any pending wrong-path discard.
  always_ff @(posedge clk) begin
    if (rst) r_state <= StRun;
    else     r_state <= w_state_d;
  end

  // Prioritised load/flush decode and next state.
  always_comb begin
    w_load_pc     = 1'b0;
    w_load_if_id  = 1'b0;
    w_load_id_ex  = 1'b0;
    w_load_ex_mem = 1'b0;
    w_load_mem_wb = 1'b0;
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;
    w_state_d     = r_state;
    if (rst) begin
      w_state_d = StRun;
    end else if (bus.dmem_stall) begin
      // Whole pipe frozen; EX holds, so a mispredict is seen again afterwards.
    end else if (bus.ex_mispredict) begin
      w_load_pc     = 1'b1;
      w_load_if_id  = 1'b1;
      w_load_id_ex  = 1'b1;
      w_load_ex_mem = 1'b1;
      w_load_mem_wb = 1'b1;
      w_flush_if_id = 1'b1;
      w_flush_id_ex = 1'b1;
      // Redirect fetch is still outstanding: the fetch that lands is wrong-path.
      w_state_d     = bus.imem_stall ? StDrain : StRun;
    end else if (bus.imem_stall || (r_state == StRun && w_hazard)) begin
      w_load_id_ex  = 1'b1;
      w_flush_id_ex = 1'b1;
      w_load_ex_mem = 1'b1;
      w_load_mem_wb = 1'b1;
    end else if (r_state == StDrain) begin
      w_load_if_id  = 1'b1;
      w_flush_if_id = 1'b1;
      w_load_id_ex  = 1'b1;
      w_flush_id_ex = 1'b1;
      w_load_ex_mem = 1'b1;
      w_load_mem_wb = 1'b1;
      w_state_d     = StRun;
    end else begin
      w_load_pc     = 1'b1;
      w_load_if_id  = 1'b1;
      w_load_id_ex  = 1'b1;
      w_load_ex_mem = 1'b1;
      w_load_mem_wb = 1'b1;
    end
  end

  assign bus.load_pc     = w_load_pc;
  assign bus.load_if_id  = w_load_if_id;
  assign bus.load_id_ex  = w_load_id_ex;
  assign bus.load_ex_mem = w_load_ex_mem;
  assign bus.load_mem_wb = w_load_mem_wb;
  assign bus.flush_if_id = w_flush_if_id;
  assign bus.flush_id_ex = w_flush_id_ex;
  assign bus.ctrl_state  = r_state;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] r_stall_cycles;
  logic [PERF_W-1:0] r_flush_count;

  // Wrapping counters: cycles without a PC load, and IF/ID flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!w_load_pc)    r_stall_cycles <= r_stall_cycles + PERF_W'(1);
      if (w_flush_if_id) r_flush_count  <= r_flush_count + PERF_W'(1);
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes reference-model expectations,
// a monitor pops and compares each cycle. Counter checks follow PIPE_CTRL_PERF_EN.
module tb_pipeline_ctrl;

  localparam int unsigned PerfW = 8;

  typedef struct {
    logic [4:0]       loads;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [1:0]       flushes; // {if_id, id_ex}
    logic             state;
    logic [PerfW-1:0] stall_cnt;
    logic [PerfW-1:0] flush_cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  // Reference model state: is a wrong-path fetch pending, plus counter values.
  bit               m_drain;
  logic [PerfW-1:0] m_stall;
  logic [PerfW-1:0] m_flush;

  pipeline_ctrl_if #(.PERF_W(PerfW)) bus ();

  pipeline_ctrl #(.PERF_W(PerfW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue what the pipeline must do with them.
  task automatic step(input bit rst_v, input bit dmem, input bit imem, input bit mis,
                      input bit ld, input logic [4:0] rd, input logic [4:0] rs1,
                      input bit u1, input logic [4:0] rs2, input bit u2);
    exp_t e;
    bit   hazard;
    @(negedge clk);
    rst               = rst_v;
    bus.dmem_stall    = dmem;
    bus.imem_stall    = imem;
    bus.ex_mispredict = mis;
    bus.ex_is_load    = ld;
    bus.ex_rd         = rd;
    bus.id_rs1_idx    = rs1;
    bus.id_uses_rs1   = u1;
    bus.id_rs2_idx    = rs2;
    bus.id_uses_rs2   = u2;

    hazard = ld && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    e.state     = m_drain;
    e.stall_cnt = m_stall;
    e.flush_cnt = m_flush;
    if (rst_v) begin
      e.loads = 5'b00000; e.flushes = 2'b00;
      m_drain = 0; m_stall = '0; m_flush = '0;
    end else begin
      if (dmem) begin
        e.loads = 5'b00000; e.flushes = 2'b00;                 // freeze everything
      end else if (mis) begin
        e.loads = 5'b11111; e.flushes = 2'b11;                 // redirect
        m_drain = imem;
      end else if (imem || (!m_drain && hazard)) begin
        e.loads = 5'b00111; e.flushes = 2'b01;                 // hold front, bubble EX
      end else if (m_drain) begin
        e.loads = 5'b01111; e.flushes = 2'b11;                 // discard wrong-path fetch
        m_drain = 0;
      end else begin
        e.loads = 5'b11111; e.flushes = 2'b00;                 // advance
      end
      if (e.loads[4] == 1'b0) m_stall = m_stall + 1;
      if (e.flushes[1])       m_flush = m_flush + 1;
    end
    exp_q.push_back(e);
  endtask

  task automatic advance();
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the queued expectation.
  initial begin
    exp_t e;
    logic [4:0] act_loads;
    logic [1:0] act_fl;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act_loads = {bus.load_pc, bus.load_if_id, bus.load_id_ex, bus.load_ex_mem,
                     bus.load_mem_wb};
        act_fl    = {bus.flush_if_id, bus.flush_id_ex};
        checks++;
        if (act_loads !== e.loads) begin
          errors++;
          $display("FAIL loads t=%0t got %b want %b", $time, act_loads, e.loads);
        end
        checks++;
        if (act_fl !== e.flushes) begin
          errors++;
          $display("FAIL flushes t=%0t got %b want %b", $time, act_fl, e.flushes);
        end
        checks++;
        if (bus.ctrl_state !== e.state) begin
          errors++;
          $display("FAIL ctrl_state t=%0t got %b want %b", $time, bus.ctrl_state, e.state);
        end
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (bus.stall_cycles !== e.stall_cnt) begin
          errors++;
          $display("FAIL stall_cycles t=%0t got %0d want %0d", $time, bus.stall_cycles,
                   e.stall_cnt);
        end
        checks++;
        if (bus.flush_count !== e.flush_cnt) begin
          errors++;
          $display("FAIL flush_count t=%0t got %0d want %0d", $time, bus.flush_count,
                   e.flush_cnt);
        end
`endif
      end
    end
  end

  initial begin
    int budget;
    checks = 0;
    errors = 0;
    m_drain = 0;
    m_stall = '0;
    m_flush = '0;
    rst = 1'b1;
    bus.dmem_stall = 0; bus.imem_stall = 0; bus.ex_mispredict = 0; bus.ex_is_load = 0;
    bus.ex_rd = '0; bus.id_rs1_idx = '0; bus.id_rs2_idx = '0;
    bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    repeat (2) @(posedge clk);

    // Reset outputs.
    step(1, 0, 0, 1, 1, 5'd3, 5'd3, 1, 5'd0, 0);
    step(1, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    advance();

    // Load x5 then consumer reads x5 as rs2: one bubble, then advance.
    step(0, 0, 0, 0, 1, 5'd5, 5'd1, 1, 5'd5, 1);
    advance();

    // Load x0, consumer reads x0: no stall.
    step(0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1);

    // imem_stall for 3 cycles with mispredict in the first.
    step(0, 0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    advance();
    advance();

    // dmem_stall for 4 cycles masking mispredict and hazard; redirect on the 5th.
    repeat (4) step(0, 1, 0, 1, 1, 5'd7, 5'd7, 1, 5'd0, 0);
    step(0, 0, 0, 1, 1, 5'd7, 5'd7, 1, 5'd0, 0);
    advance();

    // Reset in DRAIN abandons the discard.
    step(0, 0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    advance();

    // Two load-use stalls and one mispredict from a clean counter state.
    step(0, 0, 0, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0);
    advance();
    step(0, 0, 0, 0, 1, 5'd4, 5'd0, 0, 5'd4, 1);
    advance();
    step(0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    advance();
    advance();

    // Randomised traffic; small index range keeps hazards frequent.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_queue left %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
